// File: rtl/bb_pkg.sv
// Shared definitions for the bb slave memory: FSM state encoding, default
// parameter values and the index-width helper.
package bb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bb_state_e;

  localparam int BB_DATA_W      = 32;
  localparam int BB_ADDR_W      = 8;
  localparam int BB_DEPTH       = 256;
  localparam int BB_WAIT_STATES = 0;

  function automatic int bb_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bb_mem_bank.sv
// Byte-lane storage array: byte-enable write port, registered read port.
// Contents are intentionally never reset.
module bb_mem_bank
  import bb_pkg::*;
#(
  parameter int DATA_W = BB_DATA_W,
  parameter int DEPTH  = BB_DEPTH,
  parameter int IDX_W  = bb_idx_w(DEPTH)
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int NB = DATA_W / 8;

  logic [NB-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) mem[wr_idx][i] <= wr_data[8*i +: 8];
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/bb_slave_mem.sv
// Peripheral-bus slave memory with configurable wait states.
// Define BB_SLAVE_MEM_ERR_EN to flag out-of-range addresses with per_err.
module bb_slave_mem
  import bb_pkg::*;
#(
  parameter int DATA_W      = BB_DATA_W,
  parameter int ADDR_W      = BB_ADDR_W,
  parameter int DEPTH       = BB_DEPTH,
  parameter int WAIT_STATES = BB_WAIT_STATES
) (
  input  logic                mclk,
  input  logic                mrst,
  input  logic                per_en,
  input  logic [ADDR_W-1:0]   per_addr,
  input  logic [DATA_W/8-1:0] per_we,
  input  logic [DATA_W-1:0]   per_din,
  output logic [DATA_W-1:0]   per_dout,
  output logic                per_rdy,
  output logic                per_err
);

  localparam int          NB    = DATA_W / 8;
  localparam int          IDX_W = bb_idx_w(DEPTH);
  localparam logic [3:0]  WS    = WAIT_STATES[3:0];

  bb_state_e         state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     we_q;
  logic [DATA_W-1:0] din_q;
  logic              err_q;

  logic              accept, commit, oor_in;
  logic [ADDR_W-1:0] wr_addr;
  logic [NB-1:0]     wr_we;
  logic [DATA_W-1:0] wr_din;
  logic              wr_oor;
  logic [NB-1:0]     bank_be;
  logic [DATA_W-1:0] rd_data;

`ifdef BB_SLAVE_MEM_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  assign oor_in = ({1'b0, per_addr} >= DEPTH_L);
  logic unused_addr;
  assign unused_addr = 1'b0;
`else
  // Upper address bits alias onto the array (index = addr mod DEPTH).
  assign oor_in = 1'b0;
  logic unused_addr;
  assign unused_addr = &{1'b0, per_addr};
`endif

  assign accept = (state == IDLE) && per_en;
  assign commit = (accept && (WS == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));

  // With zero wait states the commit edge is the accept edge, so the
  // write must come straight from the bus rather than the latched copy.
  always_comb begin
    wr_addr = addr_q;
    wr_we   = we_q;
    wr_din  = din_q;
    wr_oor  = err_q;
    if (state == IDLE) begin
      wr_addr = per_addr;
      wr_we   = per_we;
      wr_din  = per_din;
      wr_oor  = oor_in;
    end
  end

  assign bank_be = (commit && !mrst && !wr_oor) ? wr_we : '0;

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (per_en) begin
          addr_q <= per_addr;
          we_q   <= per_we;
          din_q  <= per_din;
          err_q  <= oor_in;
          cnt    <= WS;
          state  <= (WS == 4'd0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bb_mem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (mclk),
    .wr_idx  (wr_addr[IDX_W-1:0]),
    .wr_be   (bank_be),
    .wr_data (wr_din),
    .rd_en   (accept && !mrst),
    .rd_idx  (per_addr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  assign per_rdy  = (state == RESP);
  assign per_err  = (state == RESP) && err_q;
  assign per_dout = (state == RESP && !err_q) ? rd_data : '0;

endmodule

// File: tb/tb_bb_slave_mem.sv
// Directed bench: three instances (defaults, 3 wait states/DEPTH 128,
// 2 wait states) exercised through one access task and one checker.
module tb_bb_slave_mem;

  logic        clk = 1'b0;
  logic        mrst;
  logic        en   [3];
  logic [7:0]  ad   [3];
  logic [3:0]  wev  [3];
  logic [31:0] di   [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        err  [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bb_slave_mem u_dut0 (
    .mclk(clk), .mrst(mrst), .per_en(en[0]), .per_addr(ad[0]), .per_we(wev[0]),
    .per_din(di[0]), .per_dout(dout[0]), .per_rdy(rdy[0]), .per_err(err[0]));

  bb_slave_mem #(.WAIT_STATES(3), .DEPTH(128)) u_dut1 (
    .mclk(clk), .mrst(mrst), .per_en(en[1]), .per_addr(ad[1]), .per_we(wev[1]),
    .per_din(di[1]), .per_dout(dout[1]), .per_rdy(rdy[1]), .per_err(err[1]));

  bb_slave_mem #(.WAIT_STATES(2)) u_dut2 (
    .mclk(clk), .mrst(mrst), .per_en(en[2]), .per_addr(ad[2]), .per_we(wev[2]),
    .per_din(di[2]), .per_dout(dout[2]), .per_rdy(rdy[2]), .per_err(err[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access; inputs are scrambled and en dropped right after acceptance.
  task automatic access(input int s, input logic [7:0] a, input logic [3:0] we,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat, output int bad);
    rd = '0; e = 1'b0; lat = -1; bad = 0;
    @(negedge clk);
    en[s] = 1'b1; ad[s] = a; wev[s] = we; di[s] = d;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(posedge clk);
      #1;
      if (n == 1) begin
        en[s] = 1'b0; ad[s] = ~a; wev[s] = ~we; di[s] = ~d;
      end
      if (rdy[s]) begin
        lat = n; rd = dout[s]; e = err[s];
        break;
      end
      if (dout[s] != 0 || err[s]) bad++;
    end
    @(posedge clk); #1;
    if (rdy[s] || dout[s] != 0 || err[s]) bad++;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, bad, k, spur;
  int          t [3];
  logic [31:0] bd [3];

  initial begin
    mrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; ad[i] = '0; wev[i] = '0; di[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), rdy[i], 0);
      chk($sformatf("rst_err%0d", i), err[i], 0);
      chk($sformatf("rst_dout%0d", i), dout[i], 0);
    end
    @(negedge clk) mrst = 1'b0;

    // zero wait states: full-word write then read
    access(0, 8'h10, 4'hF, 32'hDEADBEEF, rd, e, lat, bad);
    chk("wr_lat0", lat, 1);
    chk("wr_err0", e, 0);
    access(0, 8'h10, 4'h0, 32'h0, rd, e, lat, bad);
    chk("rd_lat0", lat, 1);
    chk("rd_data0", rd, 32'hDEADBEEF);
    chk("rd_quiet0", bad, 0);

    // byte enables
    access(0, 8'h20, 4'hF, 32'h11223344, rd, e, lat, bad);
    access(0, 8'h20, 4'b0101, 32'hAABBCCDD, rd, e, lat, bad);
    access(0, 8'h20, 4'h0, 32'h0, rd, e, lat, bad);
    chk("be_data", rd, 32'h11BB33DD);

    // three wait states, DEPTH 128, out-of-range handling
    access(1, 8'h10, 4'hF, 32'h11111111, rd, e, lat, bad);
    chk("ws3_wr_lat", lat, 4);
    access(1, 8'h90, 4'hF, 32'h0000005A, rd, e, lat, bad);
    chk("ws3_oor_lat", lat, 4);
`ifdef BB_SLAVE_MEM_ERR_EN
    chk("oor_wr_err", e, 1);
`else
    chk("oor_wr_err", e, 0);
`endif
    access(1, 8'h10, 4'h0, 32'h0, rd, e, lat, bad);
    chk("ws3_rd_lat", lat, 4);
    chk("ws3_rd_quiet", bad, 0);
`ifdef BB_SLAVE_MEM_ERR_EN
    chk("alias_data", rd, 32'h11111111);
`else
    chk("alias_data", rd, 32'h0000005A);
`endif
    access(1, 8'h90, 4'h0, 32'h0, rd, e, lat, bad);
`ifdef BB_SLAVE_MEM_ERR_EN
    chk("oor_rd_data", rd, 32'h0);
    chk("oor_rd_err", e, 1);
`else
    chk("oor_rd_data", rd, 32'h0000005A);
    chk("oor_rd_err", e, 0);
`endif

    // back-to-back reads with en held high
    access(1, 8'h01, 4'hF, 32'hA1A1A1A1, rd, e, lat, bad);
    access(1, 8'h02, 4'hF, 32'hB2B2B2B2, rd, e, lat, bad);
    access(1, 8'h03, 4'hF, 32'hC3C3C3C3, rd, e, lat, bad);
    for (int i = 0; i < 3; i++) begin t[i] = -1; bd[i] = '0; end
    k = 0;
    @(negedge clk);
    en[1] = 1'b1; ad[1] = 8'h01; wev[1] = 4'h0;
    @(posedge clk);
    for (int c = 1; c <= 40 && k < 3; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      if (rdy[1]) begin
        t[k] = c; bd[k] = dout[1]; k++;
        if (k < 3) ad[1] = 8'(k + 1);
        else       en[1] = 1'b0;
      end
    end
    en[1] = 1'b0;
    chk("b2b_t0", t[0], 4);
    chk("b2b_t1", t[1], 9);
    chk("b2b_t2", t[2], 14);
    chk("b2b_d0", bd[0], 32'hA1A1A1A1);
    chk("b2b_d1", bd[1], 32'hB2B2B2B2);
    chk("b2b_d2", bd[2], 32'hC3C3C3C3);

    // reset during WAIT of a write on the two-wait-state instance
    access(2, 8'h30, 4'hF, 32'h0BADF00D, rd, e, lat, bad);
    chk("ws2_wr_lat", lat, 3);
    @(negedge clk);
    en[2] = 1'b1; ad[2] = 8'h30; wev[2] = 4'hF; di[2] = 32'h12345678;
    @(posedge clk); #1;
    en[2] = 1'b0; mrst = 1'b1;
    spur = 0;
    @(posedge clk); #1;
    mrst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rdy[2]) spur++;
      @(posedge clk); #1;
    end
    chk("rst_no_rdy", spur, 0);
    access(2, 8'h30, 4'h0, 32'h0, rd, e, lat, bad);
    chk("rst_rd_lat", lat, 3);
    chk("rst_rd_data", rd, 32'h0BADF00D);
    access(0, 8'h10, 4'h0, 32'h0, rd, e, lat, bad);
    chk("mem_kept", rd, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
